// File: rtl/fg_pkg.sv
// Shared constants for the Wishbone arbitrary-waveform generator: register map,
// sample memory geometry and CTRL bit positions.
package fg_pkg;
  localparam logic [11:0] FG_CTRL        = 12'h000;
  localparam logic [11:0] FG_PERIOD      = 12'h004;
  localparam logic [11:0] FG_LENGTH      = 12'h008;
  localparam logic [11:0] FG_STATUS      = 12'h00C;
  localparam logic [11:0] FG_SAMPLE_BASE = 12'h100;

  localparam int NUM_SAMPLES = 32;
  localparam int IDX_W       = 5;
  localparam int RUN_BIT     = 0;
endpackage

// File: rtl/fg_wb_slave.sv
// Wishbone slave: address decode, single-cycle ack, control registers,
// sample memory and registered read-data mux.
module fg_wb_slave
  import fg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          PERIOD_W  = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               stb_i,
  input  logic                               cyc_i,
  input  logic                               we_i,
  input  logic [3:0]                         sel_i,
  input  logic [31:0]                        adr_i,
  input  logic [31:0]                        dat_i,
  output logic                               ack_o,
  output logic [31:0]                        dat_o,
  output logic                               run_o,
  output logic [PERIOD_W-1:0]                period_o,
  output logic [IDX_W-1:0]                   length_o,
  output logic [NUM_SAMPLES-1:0][7:0]        samples_o,
  input  logic [IDX_W-1:0]                   status_idx_i,
  input  logic [7:0]                         status_dac_i
);
  logic                        ack_q, run_q;
  logic [PERIOD_W-1:0]         period_q;
  logic [IDX_W-1:0]            length_q;
  logic [NUM_SAMPLES-1:0][7:0] samples_q;
  logic [31:0]                 rd_d, rd_q;
  logic [11:0]                 off;
  logic                        sel, req, is_smp;
  logic [IDX_W-1:0]            smp_idx;
  logic                        unused_ok;

  assign sel     = (adr_i[31:12] == BASE_ADDR[31:12]);
  assign req     = stb_i & cyc_i & sel & ~ack_q;
  assign off     = {adr_i[11:2], 2'b00};
  assign is_smp  = (off[11:IDX_W+2] == FG_SAMPLE_BASE[11:IDX_W+2]);
  assign smp_idx = adr_i[IDX_W+1:2];
  assign unused_ok = ^{sel_i, dat_i};

  always_comb begin
    rd_d = '0;
    if (is_smp) rd_d[7:0] = samples_q[smp_idx];
    else begin
      unique case (off)
        FG_CTRL:   rd_d[RUN_BIT]        = run_q;
        FG_PERIOD: rd_d[PERIOD_W-1:0]   = period_q;
        FG_LENGTH: rd_d[IDX_W-1:0]      = length_q;
        FG_STATUS: rd_d = {16'h0, status_dac_i, {(8-IDX_W){1'b0}}, status_idx_i};
        default:   rd_d = '0;
      endcase
    end
  end

  // The write lands on the same edge that raises ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q     <= 1'b0;
      rd_q      <= '0;
      run_q     <= 1'b0;
      period_q  <= '0;
      length_q  <= '0;
      samples_q <= '0;
    end else begin
      ack_q <= req;
      rd_q  <= req ? rd_d : '0;
      if (req && we_i) begin
        if (is_smp) samples_q[smp_idx] <= dat_i[7:0];
        else begin
          case (off)
            FG_CTRL:   run_q    <= dat_i[RUN_BIT];
            FG_PERIOD: period_q <= dat_i[PERIOD_W-1:0];
            FG_LENGTH: length_q <= dat_i[IDX_W-1:0];
            default:   ;
          endcase
        end
      end
    end
  end

  assign ack_o     = ack_q;
  assign dat_o     = rd_q;
  assign run_o     = run_q;
  assign period_o  = period_q;
  assign length_o  = length_q;
  assign samples_o = samples_q;
endmodule

// File: rtl/function_generator.sv
// Arbitrary-waveform generator top: period counter, sample index and the
// registered DAC output, fed by the Wishbone register block.
module function_generator
  import fg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          NUM_SAMPLES = 32,
  parameter int          PERIOD_W    = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [7:0]  dac_o,
  output logic [7:0]  dac_oeb_o
);
  logic                                run;
  logic [PERIOD_W-1:0]                 period;
  logic [IDX_W-1:0]                    length;
  logic [fg_pkg::NUM_SAMPLES-1:0][7:0] samples;
  logic [PERIOD_W-1:0]                 cnt_q, cnt_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic [7:0]                          dac_q;

  fg_wb_slave #(.BASE_ADDR(BASE_ADDR), .PERIOD_W(PERIOD_W)) u_slv (
    .clk_i(wb_clk_i), .rst_i(wb_rst_i),
    .stb_i(wbs_stb_i), .cyc_i(wbs_cyc_i), .we_i(wbs_we_i), .sel_i(wbs_sel_i),
    .adr_i(wbs_adr_i), .dat_i(wbs_dat_i), .ack_o(wbs_ack_o), .dat_o(wbs_dat_o),
    .run_o(run), .period_o(period), .length_o(length), .samples_o(samples),
    .status_idx_i(idx_q), .status_dac_i(dac_q)
  );

  // Counter above a freshly lowered PERIOD simply wraps through zero.
  always_comb begin
    cnt_d = '0;
    idx_d = '0;
    if (run) begin
      if (cnt_q == period) begin
        idx_d = (idx_q >= length) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
      idx_q <= '0;
      dac_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      dac_q <= samples[idx_q];
    end
  end

  assign dac_o     = dac_q;
  assign dac_oeb_o = 8'h00;
endmodule

// File: tb/tb_function_generator.sv
// Self-checking bench for function_generator: register table, playback
// sequences and randomized waveforms against a closed-form sample model.
module tb_function_generator;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0, rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic [7:0]  dac, oeb;

  int errors = 0, checks = 0;
  logic [7:0] smp [32];

  always #5 clk = ~clk;

  function_generator dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat), .dac_o(dac), .dac_oeb_o(oeb)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus access; returns at the falling edge after the ack edge.
  task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                         output logic [31:0] q);
    int k;
    @(negedge clk);
    adr = a; wdat = d; we = w; stb = 1'b1; cyc = 1'b1;
    for (k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (ack) break;
    end
    q = rdat;
    chk("ack_latency", k, 0);
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [11:0] off, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(BASE | off, 1'b1, d, q);
  endtask

  task automatic rd(input logic [11:0] off, output logic [31:0] q);
    wb_xfer(BASE | off, 1'b0, 32'h0, q);
  endtask

  // Expected dac_o n edges after the RUN=1 write edge (started from index 0).
  function automatic logic [7:0] exp_dac(input int n, input int p, input int l);
    int m;
    m = (n == 0) ? 0 : n - 1;
    return smp[(m / (p + 1)) % (l + 1)];
  endfunction

  task automatic load(input int p, input int l);
    wr(12'h000, 0);
    for (int i = 0; i <= l; i++) wr(12'h100 + 12'(i * 4), {24'h0, smp[i]});
    wr(12'h004, p);
    wr(12'h008, l);
  endtask

  task automatic play(input string name, input int p, input int l, input int ncyc);
    wr(12'h000, 1);
    chk({name, "_n0"}, dac, exp_dac(0, p, l));
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk); #1;
      chk(name, dac, exp_dac(n, p, l));
    end
  endtask

  typedef struct {
    logic [11:0] off;
    logic [31:0] wd;
    logic [31:0] exp;
  } reg_vec_t;

  initial begin
    reg_vec_t vt [9];
    logic [31:0] q;
    int hits, bad, seen10, seen20, p, l;

    vt[0] = '{12'h004, 32'h0000_1234, 32'h0000_1234};
    vt[1] = '{12'h008, 32'h0000_0007, 32'h0000_0007};
    vt[2] = '{12'h10C, 32'h0000_00A5, 32'h0000_00A5};
    vt[3] = '{12'h004, 32'hABCD_5678, 32'h0000_5678};
    vt[4] = '{12'h008, 32'h0000_00FF, 32'h0000_001F};
    vt[5] = '{12'h17C, 32'h0000_01FF, 32'h0000_00FF};
    vt[6] = '{12'h010, 32'h0000_0005, 32'h0000_0000};
    vt[7] = '{12'h00C, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[8] = '{12'h000, 32'h0000_0000, 32'h0000_0000};

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dac", dac, 0);
    chk("rst_ack", ack, 0);
    chk("rst_dat", rdat, 0);
    chk("oeb", oeb, 0);
    @(negedge clk) rst = 1'b0;
    rd(12'h00C, q); chk("rst_status", q, 0);
    rd(12'h114, q); chk("rst_sample5", q, 0);

    // Register table: write, ack width, readback
    foreach (vt[i]) begin
      wr(vt[i].off, vt[i].wd);
      @(posedge clk); #1;
      chk("ack_width", ack, 0);
      rd(vt[i].off, q);
      chk($sformatf("readback_%h", vt[i].off), q, vt[i].exp);
    end

    // Unselected address is never acked
    hits = 0;
    @(negedge clk);
    adr = 32'h4000_0000; stb = 1'b1; cyc = 1'b1; we = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack) hits++;
    end
    @(negedge clk) begin stb = 1'b0; cyc = 1'b0; end
    chk("unselected_ack", hits, 0);

    // Staircase, each value held 3 clocks
    smp[0] = 10; smp[1] = 20; smp[2] = 30; smp[3] = 40;
    load(2, 3);
    play("stair", 2, 3, 26);

    // PERIOD=0 toggle
    smp[0] = 8'h00; smp[1] = 8'hFF;
    load(0, 1);
    play("toggle", 0, 1, 8);

    // Shrinking LENGTH while sitting on index 3
    smp[0] = 10; smp[1] = 20; smp[2] = 30; smp[3] = 40;
    load(9, 3);
    wr(12'h000, 1);
    hits = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (dac == 8'd40) begin hits = 1; break; end
    end
    chk("reach_idx3", hits, 1);
    wr(12'h008, 1);
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (dac != 8'd40) break;
    end
    chk("shrink_wrap", dac, 10);
    bad = 0; seen10 = 0; seen20 = 0;
    repeat (45) begin
      @(posedge clk); #1;
      if (dac == 8'd10) seen10 = 1;
      else if (dac == 8'd20) seen20 = 1;
      else bad++;
    end
    chk("shrink_bad", bad, 0);
    chk("shrink_seen", {seen10[0], seen20[0]}, 2'b11);

    // Stop mid-run
    wr(12'h000, 0);
    @(posedge clk); @(posedge clk); #1;
    chk("stop_dac", dac, 10);
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (dac != 8'd10) bad++;
    end
    chk("stop_hold", bad, 0);

    // Reset mid-run
    wr(12'h000, 1);
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_dac", dac, 0);
    chk("midrst_ack", ack, 0);
    @(negedge clk) rst = 1'b0;
    rd(12'h000, q); chk("midrst_run", q, 0);
    rd(12'h100, q); chk("midrst_sample0", q, 0);

    // Randomized waveforms
    for (int it = 0; it < 6; it++) begin
      p = $urandom_range(0, 3);
      l = $urandom_range(0, 9);
      for (int i = 0; i < 32; i++) smp[i] = 8'($urandom);
      load(p, l);
      play($sformatf("rand%0d", it), p, l, (p + 1) * (l + 1) * 2 + 3);
    end
    wr(12'h000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/function_generator.md
Name: function_generator

Overview:
- Wishbone-programmable arbitrary-waveform generator for the Caravel user project area.
- Firmware loads up to 32 8-bit samples, a sample period and a waveform length over the management Wishbone bus.
- When running, the block replays the samples cyclically on an 8-bit parallel DAC bus, which drives mprj_io[15:8].

Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone base address of the block.
- NUM_SAMPLES, 32, sample memory depth; must be a power of 2.
- PERIOD_W, 16, width of the period register.

Ports:
- wb_clk_i  input  1  system clock; every flop is on the rising edge.
- wb_rst_i  input  1  synchronous, active-high reset.
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_we_i  input  1  write enable.
- wbs_sel_i  input  4  byte selects; ignored, every write is a full-word write.
- wbs_adr_i  input  32  byte address.
- wbs_dat_i  input  32  write data.
- wbs_ack_o  output  1  transfer acknowledge.
- wbs_dat_o  output  32  read data.
- dac_o  output  8  current sample; drives io_out[15:8].
- dac_oeb_o  output  8  pad output-enable bar; constant 8'h00 (driven).

Behaviour:
- Address decode: an access is selected when wbs_adr_i[31:12] == BASE_ADDR[31:12].
- Registers, as offsets from BASE_ADDR:
  - 0x000 CTRL: bit0 RUN.
  - 0x004 PERIOD: bits[PERIOD_W-1:0].
  - 0x008 LENGTH: bits[4:0], last sample index.
  - 0x00C STATUS, read-only: bits[4:0] index, bits[15:8] dac_o.
  - 0x100–0x17C SAMPLE[i]: word i = (adr[6:2]), bits[7:0] used.
- Reads return zeros in unused bits. Undefined selected offsets read 0; writes to them are acked and ignored. Writes to STATUS are ignored.
- Handshake:
  - When stb & cyc & selected & !ack, wbs_ack_o is 1 on the next cycle for exactly one cycle.
  - wbs_dat_o is valid in the same cycle as ack.
  - The write takes effect at the ack edge.
  - Unselected addresses are never acked.
- Reset values: RUN=0, PERIOD=0, LENGTH=0, all SAMPLE=0, counter=0, index=0, dac_o=0, wbs_ack_o=0, wbs_dat_o=0.
- Playback when RUN=1:
  - A cycle counter counts 0..PERIOD.
  - When counter == PERIOD, the counter goes to 0 and index advances.
  - Index advance: if index >= LENGTH, index goes to 0; otherwise index+1.
  - Each sample therefore lasts PERIOD+1 clocks. PERIOD=0 advances every clock.
- RUN=0: counter and index are held at 0.
- dac_o is registered: dac_o <= SAMPLE[index] on every clock, giving one-cycle latency from an index change.
- Starting from stop: after a write of RUN=1, dac_o shows SAMPLE[0], and the first advance occurs PERIOD+1 clocks after the write edge.
- Writing RUN=0 mid-waveform: index goes to 0 on the next edge, and dac_o shows SAMPLE[0] one cycle later.
- LENGTH written below the current index: the next advance wraps to 0 (>= compare). There is no out-of-range index.
- Sample writes during playback are legal. The new value appears on dac_o the cycle after the index next reads it. No tearing: dac_o always shows the old byte or the new byte, never a mix.
- PERIOD written mid-sample: the new value is used in the compare immediately. If counter > new PERIOD, the counter runs up to 2^PERIOD_W−1 and wraps to 0 before the compare can match. This wrap is accepted and documented.
- wb_rst_i asserted at any time, including mid-transfer, forces every reset value on the next edge. Any pending ack is dropped.

Decomposition:
- Package fg_pkg holds:
  - register offset constants (FG_CTRL, FG_PERIOD, FG_LENGTH, FG_STATUS, FG_SAMPLE_BASE);
  - NUM_SAMPLES and the index width (5);
  - CTRL bit position RUN_BIT.
- One sub-module, fg_wb_slave: Wishbone decode, ack generation, register and sample-memory storage, read mux.
- The top function_generator holds the counter, index and dac_o register.

Test Plan:
- Reset: assert wb_rst_i for 2 cycles -> dac_o=0, wbs_ack_o=0, STATUS reads 0, SAMPLE[5] reads 0.
- Register access: write PERIOD=0x1234, LENGTH=7, SAMPLE[3]=0xA5 -> each write acked exactly 1 cycle after strobe; readbacks return 0x1234, 7, 0xA5. A read at offset 0x010 returns 0 and is acked. An address 0x4000_0000 gets no ack.
- Playback: SAMPLE[0..3]=10,20,30,40, LENGTH=3, PERIOD=2, then RUN=1 -> dac_o sequence 10,20,30,40,10… with each value held 3 clocks.
- PERIOD=0, LENGTH=1, samples 0x00/0xFF, RUN=1 -> dac_o toggles every clock.
- Shrinking LENGTH: while running with index=3, write LENGTH=1 -> next advance goes to index 0, after which only SAMPLE[0] and SAMPLE[1] are output.
- Stop and reset mid-run: write RUN=0 -> dac_o=SAMPLE[0] within 2 cycles and stays there. Restarting with RUN=1, then asserting wb_rst_i mid-run -> dac_o=0 one edge later and RUN reads 0.
